day_of_week_ctrl: RTL
=====================

// Module: day_of_week_ctrl
// PURPOSE
//  Day-of-week sequencer feeding the 3-digit seven-segment day decoder (Mon..Sun).
//  Holds the current day index 0..6 (0=Mon ... 6=Sun) and advances it on the
//  calendar's midnight tick.
//  Provides a user SET mode (mode/inc/dec button pulses) with a blink-blank
//  strobe for the display.
//  Sits between the clock/calendar timebase and the day decoder; drives the
//  decoder's 7-bit index input.
// PARAMETERS
//  BLINK_DIV    25_000_000   clk cycles per blank half-period in SET (0.5 s @ 50 MHz); >=2
//  TIMEOUT_CYC  500_000_000  idle clk cycles before SET auto-exits (SET_TIMEOUT_EN only); >=2
// PORTS
//  clk        in   1  system clock, all logic rising-edge
//  rst_n      in   1  asynchronous active-low reset
//  day_tick   in   1  1-cycle pulse: midnight rollover from the timebase
//  btn_mode   in   1  1-cycle debounced pulse: toggle RUN<->SET
//  btn_inc    in   1  1-cycle debounced pulse: day+1 (SET only)
//  btn_dec    in   1  1-cycle debounced pulse: day-1 (SET only)
//  day_idx    out  7  current day 0..6, bits [6:3] always 0; to the decoder index input
//  blank      out  1  1 = display should blank (blink phase); 0 in RUN
//  set_mode   out  1  1 while in SET
//  week_wrap  out  1  1-cycle pulse when a day_tick-driven advance wraps Sun(6)->Mon(0)
// BEHAVIOUR
//  - All outputs registered; each effect is visible 1 cycle after the input sample.
//  - Reset (async assert, sync release): day_idx=0, state RUN, set_mode=0, blank=0,
//    week_wrap=0, pend=0, blink_cnt=0, idle_cnt=0. Reset mid-SET returns to RUN with day 0.
//  - FSM: RUN --btn_mode--> SET; SET --btn_mode--> RUN; SET --timeout--> RUN
//    (SET_TIMEOUT_EN only).
//  - RUN: day_tick advances day_idx mod 7 (6->0 asserts week_wrap for 1 cycle).
//    btn_inc/btn_dec ignored.
//  - SET: btn_inc: 6->0 else +1; btn_dec: 0->6 else -1; inc&dec same cycle: no change.
//    Edits never assert week_wrap.
//  - btn_mode has priority: mode+inc/dec in the same cycle changes state only, day unchanged.
//  - day_tick in SET: sets pend (multiple ticks collapse to 1). No immediate change.
//  - First RUN cycle after SET exit: advance = pend + day_tick (0,1,2), mod 7; pend
//    clears.
//  - week_wrap asserts if this advance crosses 6->0 (e.g. 5+2 -> 0, 6+1 -> 0, 6+2 -> 1).
//  - Blink: entering SET clears blink_cnt and blank=0. blink_cnt counts 0..BLINK_DIV-1
//    and blank toggles at wrap.
//  - Leaving SET forces blank=0 on the same edge that clears set_mode.
//  - day_idx is never outside 0..6; the decoder's mod-7 is therefore identity.
// CONFIGURATION
//  - SET_TIMEOUT_EN defined: idle_cnt clears on SET entry and on any btn_* pulse.
//    Otherwise it increments each SET cycle.
//  - When idle_cnt reaches TIMEOUT_CYC-1, the next edge returns to RUN (same exit rules
//    as btn_mode, pend applied).
//  - SET_TIMEOUT_EN undefined: no idle_cnt logic; SET is left only via btn_mode or reset.
// TESTING (bench params BLINK_DIV=4, TIMEOUT_CYC=16)
//  1. Reset, then 7 day_tick pulses -> day_idx 1,2,3,4,5,6,0; week_wrap high only on
//     the 6->0 cycle.
//  2. btn_mode, btn_dec x2 from day 0 -> set_mode=1, day_idx 6 then 5.
//     btn_inc+btn_dec together -> stays 5.
//  3. In SET at day 6: day_tick x3, then btn_mode with day_tick on the first RUN cycle ->
//     day_idx 1, week_wrap=1 once.
//  4. Hold SET 12 cycles -> blank toggles every 4 cycles starting 0.
//     btn_mode -> blank=0 and set_mode=0 on the same cycle.
//  5. SET_TIMEOUT_EN: enter SET, btn_inc at cycle 10, then idle -> exit exactly 16
//     cycles after the btn_inc. Undefined: still SET after 100 cycles.
//  6. Assert rst_n=0 mid-SET at day 4 with blank=1 -> all outputs 0 immediately
//     (asynchronously), state RUN.

Source files
------------

// File: rtl/day_of_week_ctrl.sv
// day_of_week_ctrl
//   Day-of-week sequencer for the 3-digit seven-segment day decoder (Mon..Sun).
//   Holds the current day index (0=Mon .. 6=Sun) and advances it on the
//   calendar's midnight tick. A user SET mode, entered and left with btn_mode,
//   lets btn_inc/btn_dec edit the day. While in SET, a blink strobe tells the
//   display when to blank.
//
//   Optional feature macro: SET_TIMEOUT_EN
//     defined   -> SET auto-exits after TIMEOUT_CYC idle cycles (no button pulse)
//     undefined -> SET is left only via btn_mode or reset
//
// Parameters
//   BLINK_DIV    clk cycles per blank half-period while in SET (>= 2)
//   TIMEOUT_CYC  idle clk cycles before SET auto-exits (SET_TIMEOUT_EN only, >= 2)
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   day_tick   in   1  1-cycle midnight rollover pulse from the timebase
//   btn_mode   in   1  1-cycle debounced pulse, toggles RUN <-> SET
//   btn_inc    in   1  1-cycle debounced pulse, day+1 (SET only)
//   btn_dec    in   1  1-cycle debounced pulse, day-1 (SET only)
//   day_idx    out  7  current day 0..6 (bits [6:3] always 0), to decoder index
//   blank      out  1  display blank request (blink phase), 0 in RUN
//   set_mode   out  1  high while in SET
//   week_wrap  out  1  1-cycle pulse when a tick-driven advance wraps Sun -> Mon

module day_of_week_ctrl #(
  parameter int unsigned BLINK_DIV   = 25_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       day_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [6:0] day_idx,
  output logic       blank,
  output logic       set_mode,
  output logic       week_wrap
);

  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

`ifdef SET_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         day_q, day_d;
  logic               pend_q, pend_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blank_q, blank_d;
  logic               wrap_q, wrap_d;
  logic [3:0]         adv_sum;
  logic               leave_set;
`ifdef SET_TIMEOUT_EN
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic               timeout_hit;
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      day_q       <= 3'd0;
      pend_q      <= 1'b0;
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
      wrap_q      <= 1'b0;
`ifdef SET_TIMEOUT_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      day_q       <= day_d;
      pend_q      <= pend_d;
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
      wrap_q      <= wrap_d;
`ifdef SET_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

`ifdef SET_TIMEOUT_EN
  // A button pulse counts as activity, so it never coincides with a timeout.
  assign timeout_hit = (idle_cnt_q == IDLE_LAST) && !btn_inc && !btn_dec;
  assign leave_set   = btn_mode || timeout_hit;
`else
  assign leave_set   = btn_mode;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    day_d       = day_q;
    pend_d      = pend_q;
    blink_cnt_d = blink_cnt_q;
    blank_d     = blank_q;
    wrap_d      = 1'b0;
    adv_sum     = {1'b0, day_q};
`ifdef SET_TIMEOUT_EN
    idle_cnt_d  = idle_cnt_q;
`endif

    case (state_q)
      ST_RUN: begin
        // pend is only ever set on the first RUN cycle after leaving SET, so
        // the advance here is 0, 1 or 2 days; sum is at most 6+2 = 8.
        adv_sum = {1'b0, day_q} + {3'b000, pend_q} + {3'b000, day_tick};
        if (adv_sum >= 4'd7) begin
          day_d  = 3'(adv_sum - 4'd7);
          wrap_d = 1'b1;
        end else begin
          day_d  = adv_sum[2:0];
        end
        pend_d      = 1'b0;
        blink_cnt_d = '0;
        blank_d     = 1'b0;
`ifdef SET_TIMEOUT_EN
        idle_cnt_d  = '0;
`endif
        if (btn_mode) begin
          state_d = ST_SET;
        end
      end

      ST_SET: begin
        // Ticks seen while editing are remembered (collapsed to one) and
        // applied on the first RUN cycle.
        if (day_tick) begin
          pend_d = 1'b1;
        end

        if (leave_set) begin
          state_d     = ST_RUN;
          blink_cnt_d = '0;
          blank_d     = 1'b0;
`ifdef SET_TIMEOUT_EN
          idle_cnt_d  = '0;
`endif
        end else begin
          // inc and dec together cancel out.
          if (btn_inc && !btn_dec) begin
            day_d = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
          end else if (btn_dec && !btn_inc) begin
            day_d = (day_q == 3'd0) ? 3'd6 : day_q - 3'd1;
          end

          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blank_d     = ~blank_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end

`ifdef SET_TIMEOUT_EN
          if (btn_inc || btn_dec) begin
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
`endif
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign day_idx   = {4'b0000, day_q};
  assign blank     = blank_q;
  assign set_mode  = (state_q == ST_SET);
  assign week_wrap = wrap_q;

endmodule
